// File: rtl/mxreg_pkg.sv
// Shared register bank map: indices, addresses and the address decoder
// used by both the load path and the read sequencer.
package mxreg_pkg;

  localparam logic [3:0] REG_A     = 4'd0;
  localparam logic [3:0] REG_X     = 4'd1;
  localparam logic [3:0] REG_Y     = 4'd2;
  localparam logic [3:0] REG_B     = 4'd3;
  localparam logic [3:0] REG_SP    = 4'd4;
  localparam logic [3:0] REG_PC    = 4'd5;
  localparam logic [3:0] REG_INSP  = 4'd6;
  localparam logic [3:0] REG_FLAGS = 4'd7;
  localparam logic [3:0] REG_T0    = 4'd8;
  localparam logic [3:0] REG_T1    = 4'd9;
  localparam logic [3:0] REG_T2    = 4'd10;
  localparam logic [3:0] REG_T3    = 4'd11;
  localparam logic [3:0] REG_R0    = 4'd12;
  localparam logic [3:0] REG_R1    = 4'd13;
  localparam logic [3:0] REG_R2    = 4'd14;
  localparam logic [3:0] REG_R3    = 4'd15;

  localparam logic [7:0] ADDR_PAIR_A  = 8'h10;
  localparam logic [7:0] ADDR_PAIR_X  = 8'h11;
  localparam logic [7:0] ADDR_PAIR_Y  = 8'h12;
  localparam logic [7:0] ADDR_PAIR_B  = 8'h13;
  localparam logic [7:0] ADDR_INSP    = 8'h16;
  localparam logic [7:0] ADDR_INSP_R2 = 8'h80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       two;
    logic [3:0] idx0;
    logic [3:0] idx1;
  } rd_map_t;

  // Pairs always list the lower bank index first.
  function automatic rd_map_t rd_decode(input logic [7:0] a);
    rd_map_t m;
    m = '0;
    unique case (1'b1)
      (a[7:4] == 4'h0): begin
        m.valid = 1'b1;
        m.idx0  = a[3:0];
      end
      (a[7:2] == ADDR_PAIR_A[7:2]): begin
        m.valid = 1'b1;
        m.two   = 1'b1;
        m.idx0  = {2'b00, a[1:0]};
        m.idx1  = REG_FLAGS;
      end
      (a == ADDR_INSP): begin
        m.valid = 1'b1;
        m.idx0  = REG_INSP;
      end
      (a == ADDR_INSP_R2): begin
        m.valid = 1'b1;
        m.two   = 1'b1;
        m.idx0  = REG_INSP;
        m.idx1  = REG_R2;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mxreg_read_map_11.sv
// Combinational read address map built on the shared decoder.
module mxreg_read_map_11
  import mxreg_pkg::*;
(
  input  logic [7:0] rd_addr,
  output logic       map_valid,
  output logic       map_two,
  output logic [3:0] idx0,
  output logic [3:0] idx1
);

  rd_map_t m;

  always_comb begin
    m         = rd_decode(rd_addr);
    map_valid = m.valid;
    map_two   = m.two;
    idx0      = m.idx0;
    idx1      = m.idx1;
  end

endmodule

// File: rtl/mxreg_read_seq_11.sv
// Register bank read sequencer: snapshots one or two registers on
// request and streams them out over valid/ready.
module mxreg_read_seq_11
  import mxreg_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int DEPTH       = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [DEPTH-1:0][WORD_LENGTH-1:0]     reg_line,
  input  logic [7:0]                            rd_addr,
  input  logic                                  rd_req,
  output logic                                  rd_busy,
  output logic                                  rd_err,
  output logic [WORD_LENGTH-1:0]                out_data,
  output logic [3:0]                            out_idx,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_last
);

  state_t state_q;
  state_t state_n;

  logic                   map_valid;
  logic                   map_two;
  logic [3:0]             map_i0;
  logic [3:0]             map_i1;
  logic                   accept;
  logic                   two_q;
  logic [3:0]             idx0_q;
  logic [3:0]             idx1_q;
  logic [WORD_LENGTH-1:0] word0_q;
  logic [WORD_LENGTH-1:0] word1_q;
  logic                   err_q;

  mxreg_read_map_11 u_map (
    .rd_addr   (rd_addr),
    .map_valid (map_valid),
    .map_two   (map_two),
    .idx0      (map_i0),
    .idx1      (map_i1)
  );

  assign accept = (state_q == IDLE) && rd_req && map_valid;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_n = BEAT0;
      BEAT0:   if (out_ready) state_n = two_q ? BEAT1 : IDLE;
      BEAT1:   if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Snapshot is taken in the accept cycle only; later bank loads are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      two_q   <= 1'b0;
      idx0_q  <= '0;
      idx1_q  <= '0;
      word0_q <= '0;
      word1_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (state_q == IDLE) && rd_req && !map_valid;
      if (accept) begin
        two_q   <= map_two;
        idx0_q  <= map_i0;
        idx1_q  <= map_i1;
        word0_q <= reg_line[map_i0];
        word1_q <= reg_line[map_i1];
      end
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    unique case (state_q)
      BEAT0: begin
        out_valid = 1'b1;
        out_last  = !two_q;
        out_data  = word0_q;
        out_idx   = idx0_q;
      end
      BEAT1: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = word1_q;
        out_idx   = idx1_q;
      end
      default: ;
    endcase
  end

  assign rd_busy = out_valid;
  assign rd_err  = err_q;

endmodule

// File: tb/tb_mxreg_read_seq_11.sv
// Self-checking bench for mxreg_read_seq_11: directed table, corner
// sequences and a queue-based random reference model.
module tb_mxreg_read_seq_11;

  localparam int W = 8;
  localparam int D = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [D-1:0][W-1:0]   reg_line;
  logic [7:0]            rd_addr;
  logic                  rd_req;
  logic                  out_ready;
  logic                  rd_busy;
  logic                  rd_err;
  logic                  out_valid;
  logic                  out_last;
  logic [W-1:0]          out_data;
  logic [3:0]            out_idx;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mxreg_read_seq_11 #(.WORD_LENGTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .reg_line  (reg_line),
    .rd_addr   (rd_addr),
    .rd_req    (rd_req),
    .rd_busy   (rd_busy),
    .rd_err    (rd_err),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".valid"}, out_valid, 0);
    chk({nm, ".last"},  out_last,  0);
    chk({nm, ".data"},  out_data,  0);
    chk({nm, ".idx"},   out_idx,   0);
    chk({nm, ".busy"},  rd_busy,   0);
    chk({nm, ".err"},   rd_err,    0);
  endtask

  task automatic chk_beat(input string nm, input logic [7:0] d,
                          input logic [3:0] i, input logic l);
    chk({nm, ".valid"}, out_valid, 1);
    chk({nm, ".data"},  out_data,  d);
    chk({nm, ".idx"},   out_idx,   i);
    chk({nm, ".last"},  out_last,  l);
  endtask

  // Address map straight from the register map table.
  function automatic void ref_map(input logic [7:0] a, output int n,
                                  output int i0, output int i1);
    n = 0; i0 = 0; i1 = 0;
    if (a < 8'h10) begin
      n = 1; i0 = int'(a);
    end else if (a >= 8'h10 && a <= 8'h13) begin
      n = 2; i0 = int'(a) - 16; i1 = 7;
    end else if (a == 8'h16) begin
      n = 1; i0 = 6;
    end else if (a == 8'h80) begin
      n = 2; i0 = 6; i1 = 14;
    end
  endfunction

  typedef struct {
    logic [7:0] addr;
    int         n;
    logic [3:0] i0;
    logic [3:0] i1;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [3:0] i;
    logic       l;
  } beat_t;

  vec_t  tbl[13];
  beat_t q[$];
  bit    err_e;
  bit    idle;
  int    rn, ri0, ri1;

  initial begin
    tbl[0]  = '{8'h00, 1, 4'd0,  4'd0};
    tbl[1]  = '{8'h0F, 1, 4'd15, 4'd0};
    tbl[2]  = '{8'h10, 2, 4'd0,  4'd7};
    tbl[3]  = '{8'h11, 2, 4'd1,  4'd7};
    tbl[4]  = '{8'h12, 2, 4'd2,  4'd7};
    tbl[5]  = '{8'h13, 2, 4'd3,  4'd7};
    tbl[6]  = '{8'h16, 1, 4'd6,  4'd0};
    tbl[7]  = '{8'h80, 2, 4'd6,  4'd14};
    tbl[8]  = '{8'h14, 0, 4'd0,  4'd0};
    tbl[9]  = '{8'h17, 0, 4'd0,  4'd0};
    tbl[10] = '{8'h20, 0, 4'd0,  4'd0};
    tbl[11] = '{8'hFF, 0, 4'd0,  4'd0};
    tbl[12] = '{8'h81, 0, 4'd0,  4'd0};

    rst = 1'b1; reg_line = '0; rd_addr = '0;
    rd_req = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk_zero("reset");

    // Single read
    reg_line[1] = 8'h5A; rd_addr = 8'h01; rd_req = 1'b1; out_ready = 1'b1;
    step();
    rd_req = 1'b0;
    chk_beat("single", 8'h5A, 4'd1, 1'b1);
    chk("single.busy", rd_busy, 1);
    step();
    chk("single.busy_after", rd_busy, 0);
    chk("single.valid_after", out_valid, 0);

    // Pair read with backpressure
    reg_line[0] = 8'h11; reg_line[7] = 8'h80;
    rd_addr = 8'h10; rd_req = 1'b1; out_ready = 1'b0;
    step();
    rd_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_beat($sformatf("bp.hold%0d", k), 8'h11, 4'd0, 1'b0);
      if (k < 2) step();
    end
    out_ready = 1'b1;
    step();
    chk_beat("bp.beat1", 8'h80, 4'd7, 1'b1);
    step();
    chk("bp.done", rd_busy, 0);

    // Snapshot isolation
    reg_line[6] = 8'h22; reg_line[14] = 8'h33;
    rd_addr = 8'h80; rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    reg_line[6] = 8'hFF; reg_line[14] = 8'hFF;
    chk_beat("snap.b0", 8'h22, 4'd6, 1'b0);
    step();
    chk_beat("snap.b1", 8'h33, 4'd14, 1'b1);
    step();
    chk("snap.done", out_valid, 0);

    // Unmapped address
    rd_addr = 8'h14; rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("unm.err", rd_err, 1);
    chk("unm.valid", out_valid, 0);
    step();
    chk("unm.err_off", rd_err, 0);
    chk("unm.valid2", out_valid, 0);
    step();
    chk("unm.valid3", out_valid, 0);

    // Request during a transfer is dropped
    reg_line[3] = 8'h44; reg_line[7] = 8'h77; reg_line[5] = 8'h55;
    rd_addr = 8'h13; rd_req = 1'b1; out_ready = 1'b0;
    step();
    chk_beat("ign.b0", 8'h44, 4'd3, 1'b0);
    rd_addr = 8'h05; out_ready = 1'b1;
    step();
    chk_beat("ign.b1", 8'h77, 4'd7, 1'b1);
    step();
    rd_req = 1'b0;
    chk("ign.valid", out_valid, 0);
    chk("ign.busy", rd_busy, 0);

    // Reset mid-transfer
    reg_line[2] = 8'h3C;
    rd_addr = 8'h12; rd_req = 1'b1; out_ready = 1'b0;
    step();
    rd_req = 1'b0;
    chk("rmid.valid", out_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("rmid");
    rd_addr = 8'h02; rd_req = 1'b1; out_ready = 1'b1;
    step();
    rd_req = 1'b0;
    chk_beat("rmid.y", 8'h3C, 4'd2, 1'b1);
    step();
    chk("rmid.done", rd_busy, 0);

    // Table of addresses with a known bank pattern
    for (int r = 0; r < D; r++) reg_line[r] = 8'hA0 + 8'(r);
    out_ready = 1'b1;
    for (int t = 0; t < 13; t++) begin
      rd_addr = tbl[t].addr; rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      chk($sformatf("tbl%0d.err", t), rd_err, tbl[t].n == 0);
      if (tbl[t].n == 0) chk($sformatf("tbl%0d.valid", t), out_valid, 0);
      for (int b = 0; b < tbl[t].n; b++) begin
        logic [3:0] ei;
        ei = (b == 0) ? tbl[t].i0 : tbl[t].i1;
        chk_beat($sformatf("tbl%0d.b%0d", t, b), 8'hA0 + 8'(ei), ei,
                 b == tbl[t].n - 1);
        step();
      end
      if (tbl[t].n == 0) step();
      chk($sformatf("tbl%0d.idle", t), rd_busy, 0);
    end

    // Random traffic against a queue model
    q.delete(); err_e = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd.valid", out_valid, q.size() != 0);
      chk("rnd.busy", rd_busy, q.size() != 0);
      chk("rnd.err", rd_err, err_e);
      if (q.size() != 0) begin
        chk("rnd.data", out_data, q[0].d);
        chk("rnd.idx", out_idx, q[0].i);
        chk("rnd.last", out_last, q[0].l);
      end
      rst = ($urandom_range(99) == 0);
      rd_req = $urandom_range(1);
      out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(1) == 0) begin
        case ($urandom_range(3))
          0: rd_addr = 8'($urandom_range(15));
          1: rd_addr = 8'h10 + 8'($urandom_range(3));
          2: rd_addr = 8'h16;
          default: rd_addr = 8'h80;
        endcase
      end else begin
        rd_addr = 8'($urandom);
      end
      for (int r = 0; r < D; r++) reg_line[r] = 8'($urandom);
      idle = (q.size() == 0);
      if (rst) begin
        q.delete();
        err_e = 0;
      end else begin
        if (!idle && out_ready) void'(q.pop_front());
        err_e = 0;
        if (idle && rd_req) begin
          ref_map(rd_addr, rn, ri0, ri1);
          if (rn == 0) err_e = 1;
          else begin
            q.push_back('{reg_line[ri0], 4'(ri0), rn == 1});
            if (rn == 2) q.push_back('{reg_line[ri1], 4'(ri1), 1'b1});
          end
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mxreg_read_seq_11.md
# mxreg_read_seq_11

Read-side companion to the register bank's load decoder. It accepts a read request carrying an 8-bit register address in the same address map used for loads. It snapshots the selected register(s) from the bank's `reg_line` output and streams them out one word per beat over a valid/ready interface. Consumers include stack-push, interrupt-save and debug-readout logic that need paired registers, such as FLAGS with A, delivered in a fixed order.

## Interface
- `WORD_LENGTH`, default 8, width of one register word.
- `DEPTH`, default 16, number of bank registers; must be 16 because the address map is fixed.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `reg_line` input DEPTH×WORD_LENGTH: live register bank contents, index 0 = A … 15 = R3.
- `rd_addr` input 8: register address, same map as loads.
- `rd_req` input 1: request strobe, sampled only while `rd_busy`=0.
- `rd_busy` output 1: high while a request is in progress.
- `rd_err` output 1: one-cycle pulse when an unmapped address is requested.
- `out_data` output WORD_LENGTH: current beat's register value.
- `out_idx` output 4: bank index of the current beat.
- `out_valid` output 1: beat valid.
- `out_ready` input 1: consumer accepts the beat.
- `out_last` output 1: current beat is the final beat of the request.

## Operation
- Address map:
  - 0x00–0x0F: single beat, index = addr[3:0].
  - 0x10/0x11/0x12/0x13: two beats, {0 or 1 or 2 or 3} then 7 (FLAGS).
  - 0x16: single beat, index 6 (INSP).
  - 0x80: two beats, 6 (INSP) then 14 (R2).
  - Any other address is unmapped.
- Beat order is ascending bank index.
- States: IDLE, BEAT0, BEAT1.
- IDLE with `rd_req`=1 and a mapped address:
  - Snapshot the selected word(s) and index(es) into internal holding registers.
  - Go to BEAT0.
- IDLE with `rd_req`=1 and an unmapped address:
  - Stay in IDLE.
  - Pulse `rd_err` for exactly one cycle.
  - Produce no beats.
- BEAT0:
  - `out_valid`=1.
  - `out_last`=1 for single-beat requests, 0 otherwise.
  - On `out_ready`, go to BEAT1 for two-beat requests, else to IDLE.
- BEAT1:
  - `out_valid`=1, `out_last`=1.
  - On `out_ready`, go to IDLE.
- While a beat is valid and `out_ready`=0, `out_data`, `out_idx` and `out_last` hold stable.
- Snapshot semantics: data is taken from `reg_line` in the accept cycle. Bank loads after acceptance do not change beats in flight.
- `rd_req` while `rd_busy`=1 is ignored, not queued.
- `rd_busy` = (state ≠ IDLE).
- Reset, including mid-transfer, forces IDLE and discards the snapshot.

## Timing
- Reset values, all registered from the cycle after `rst` is sampled high: `out_valid`=0, `out_last`=0, `out_data`=0, `out_idx`=0, `rd_busy`=0, `rd_err`=0.
- Request latency: `rd_req` accepted at edge N gives `out_valid`=1 after edge N, i.e. one cycle.
- `rd_err` is high for the single cycle after the accept edge.
- A beat transfers on each edge where `out_valid` and `out_ready` are both 1.
- With `out_ready` held high:
  - A single-beat request takes 1 beat cycle.
  - A two-beat request takes 2 consecutive beat cycles.
- After the last beat transfers, `rd_busy` is 0 in the following cycle, so the next request can be accepted then.
- Minimum request-to-request spacing is therefore beats+1 cycles.
- `out_ready` is never required before `out_valid`.

## Structure
- Shared package `mxreg_pkg` holds:
  - Register index constants (A=0 … R3=15).
  - Address constants (0x10–0x13, 0x16, 0x80).
  - The state enum {IDLE, BEAT0, BEAT1}.
- The load decoder must be moved onto the same package so the two ends cannot drift.
- One combinational sub-module, `mxreg_read_map_11`:
  - Input: `rd_addr`.
  - Outputs: `map_valid`, `map_two`, `idx0[3:0]`, `idx1[3:0]`.
- The top level holds the FSM, the two snapshot word registers and the two index registers.

## Test plan
- Single read:
  - Stimulus: reset, set `reg_line[1]`=0x5A, `rd_addr`=0x01, pulse `rd_req`, `out_ready`=1.
  - Required response: one beat, `out_data`=0x5A, `out_idx`=1, `out_last`=1, one cycle after accept; `rd_busy` low the cycle after.
- Pair read with backpressure:
  - Stimulus: A=0x11, FLAGS=0x80, `rd_addr`=0x10, `out_ready` low for 3 cycles then high.
  - Required response: beat 0 holds {0x11, idx 0, last 0} stable for 3 cycles, then beat 1 is {0x80, idx 7, last 1}.
- Snapshot isolation:
  - Stimulus: `rd_addr`=0x80 with INSP=0x22 and R2=0x33; change both to 0xFF the cycle after accept.
  - Required response: beats still deliver 0x22 (idx 6) then 0x33 (idx 14).
- Unmapped and ignored requests:
  - Stimulus: `rd_addr`=0x14.
  - Required response: `rd_err` high exactly 1 cycle, `out_valid` never asserts.
  - Stimulus: a new `rd_req` during a 0x13 transfer.
  - Required response: the new request is ignored; the second beat is still idx 7.
- Reset mid-transfer:
  - Stimulus: assert `rst` during BEAT0 of 0x12.
  - Required response: all outputs 0 next cycle; a subsequent 0x02 read returns Y correctly.
